// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch, response FIFO and redirect squashing.
// Define YSYX_25060173_IFU_PERF_EN to add the fetch/stall performance counter outputs.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
`ifdef YSYX_25060173_IFU_PERF_EN
  output logic        if_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`else
  output logic        if_err
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  logic            run_q;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic        err_mem  [FIFO_DEPTH];

  logic [SumW-1:0] inflight;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Credit covers both words in flight and words buffered, so a response always has a slot.
  assign inflight       = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = run_q && !redirect_valid && (inflight < SumW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign if_valid       = (cnt_q != '0);
  assign pop            = if_valid && if_ready;

  assign if_inst = if_valid ? inst_mem[rd_ptr_q] : 32'd0;
  assign if_pc   = if_valid ? pc_mem[rd_ptr_q]   : 32'd0;
  assign if_err  = if_valid && err_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_d      = out_q + CntW'(req_fire) - CntW'(imem_resp_valid);
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CntW'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    // Everything still in flight after this edge belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      drop_d     = out_d;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      err_mem[wr_ptr_q]  <= imem_resp_err;
    end
  end

`ifdef YSYX_25060173_IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (pop ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + ((if_ready && !if_valid) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  resp_has_owner_a: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (out_q != '0))
    else $error("ifu: instruction response with no outstanding request");

endmodule
